pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage. It replaces the fixed 32-bit PC register with:
- a valid/ready fetch handshake
- a control FSM with IDLE, RUN and HALT states
- prioritised redirects (JAL, JALR, BRANCH, TRAP)
- a redirect epoch counter that downstream stages use to squash stale fetched instructions

---
 rtl/pc_gen.sv | 153 +++++++++++++++
 tb/tb_pc_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Program-counter generator for the fetch stage. Presents fetch_pc
//            on a valid/ready handshake, steps by 4 per accepted fetch, and
//            takes prioritised redirects (JAL, JALR, BRANCH, TRAP). Each
//            accepted redirect bumps an epoch tag so later stages can squash
//            instructions fetched down the old path.
// Ports    : clock, reset          - clock, synchronous active-high reset
//            start, halt           - leave IDLE / request stop of fetching
//            fetch_ready           - instruction memory accepts fetch_pc
//            fetch_valid, fetch_pc, fetch_epoch - fetch request and its tag
//            redirect_valid, redirect_sel, *_target - redirect request
//            halted                - FSM is in HALT
//            misalign, misalign_addr - misaligned redirect report
// Config   : PC_MISALIGN_EN - when defined, a misaligned non-TRAP target is
//            replaced by TRAP_VEC and reported on misalign/misalign_addr;
//            when undefined, target bits [1:0] are simply forced to zero.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
   parameter int                XLEN      = 32,
   parameter logic [XLEN-1:0]   RESET_VEC = '0,
   parameter logic [XLEN-1:0]   TRAP_VEC  = XLEN'('h100),
   parameter int                EPOCH_W   = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 halt,
   input  logic                 fetch_ready,
   output logic                 fetch_valid,
   output logic [XLEN-1:0]      fetch_pc,
   output logic [EPOCH_W-1:0]   fetch_epoch,
   input  logic                 redirect_valid,
   input  logic [1:0]           redirect_sel,
   input  logic [XLEN-1:0]      jal_target,
   input  logic [XLEN-1:0]      jalr_target,
   input  logic [XLEN-1:0]      branch_target,
   output logic                 halted,
   output logic                 misalign,
   output logic [XLEN-1:0]      misalign_addr
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam logic [1:0] SEL_JAL    = 2'd0;
   localparam logic [1:0] SEL_JALR   = 2'd1;
   localparam logic [1:0] SEL_BRANCH = 2'd2;
   localparam logic [1:0] SEL_TRAP   = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic             redirect_take;
   logic             handshake;
   logic [XLEN-1:0]  eff_target;
   logic [XLEN-1:0]  load_target;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start) state_next = ST_RUN;
         ST_RUN:  if (halt)  state_next = ST_HALT;
         ST_HALT: if (!halt) state_next = ST_RUN;
         default:            state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs, decoded straight from the state flops
   // ---------------------------------------------------------------------
   always_comb begin
      fetch_valid = 1'b0;
      halted      = 1'b0;
      case (state)
         ST_RUN:  fetch_valid = 1'b1;
         ST_HALT: halted      = 1'b1;
         default: ;
      endcase
   end

   // Redirects are only honoured once the core has been started.
   assign redirect_take = redirect_valid && ((state == ST_RUN) || (state == ST_HALT));
   assign handshake     = fetch_valid && fetch_ready;

   always_comb begin
      eff_target = TRAP_VEC;
      case (redirect_sel)
         SEL_JAL:    eff_target = jal_target;
         SEL_JALR:   eff_target = {jalr_target[XLEN-1:1], 1'b0};
         SEL_BRANCH: eff_target = branch_target;
         SEL_TRAP:   eff_target = TRAP_VEC;
         default:    eff_target = TRAP_VEC;
      endcase
   end

`ifdef PC_MISALIGN_EN
   logic target_misaligned;

   // TRAP_VEC itself is never treated as a misaligned target.
   assign target_misaligned = (redirect_sel != SEL_TRAP) && (eff_target[1:0] != 2'b00);
   assign load_target       = target_misaligned ? TRAP_VEC : eff_target;

   always_ff @(posedge clock) begin
      if (reset) begin
         misalign      <= 1'b0;
         misalign_addr <= '0;
      end else begin
         misalign <= redirect_take && target_misaligned;
         if (redirect_take && target_misaligned) begin
            misalign_addr <= eff_target;
         end
      end
   end
`else
   assign load_target   = {eff_target[XLEN-1:2], 2'b00};
   assign misalign      = 1'b0;
   assign misalign_addr = '0;
`endif

   // ---------------------------------------------------------------------
   // PC and epoch: redirect beats handshake, handshake beats hold
   // ---------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc    <= RESET_VEC;
         fetch_epoch <= '0;
      end else if (redirect_take) begin
         fetch_pc    <= load_target;
         fetch_epoch <= fetch_epoch + EPOCH_W'(1);
      end else if (handshake) begin
         fetch_pc    <= fetch_pc + XLEN'(4);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Purpose  : Self-checking bench for pc_gen. A behavioural reference model
//            produces the expected next-cycle outputs whenever inputs are
//            driven; those are queued and compared after the clock edge.
//            Directed scenarios are followed by a randomised phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

   localparam int          XLEN      = 32;
   localparam int          EPOCH_W   = 2;
   localparam logic [31:0] RESET_VEC = 32'h0;
   localparam logic [31:0] TRAP_VEC  = 32'h100;

   logic               clock = 1'b0;
   logic               reset;
   logic               start;
   logic               halt;
   logic               fetch_ready;
   logic               fetch_valid;
   logic [XLEN-1:0]    fetch_pc;
   logic [EPOCH_W-1:0] fetch_epoch;
   logic               redirect_valid;
   logic [1:0]         redirect_sel;
   logic [XLEN-1:0]    jal_target;
   logic [XLEN-1:0]    jalr_target;
   logic [XLEN-1:0]    branch_target;
   logic               halted;
   logic               misalign;
   logic [XLEN-1:0]    misalign_addr;

   pc_gen #(
      .XLEN      (XLEN),
      .RESET_VEC (RESET_VEC),
      .TRAP_VEC  (TRAP_VEC),
      .EPOCH_W   (EPOCH_W)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .halt           (halt),
      .fetch_ready    (fetch_ready),
      .fetch_valid    (fetch_valid),
      .fetch_pc       (fetch_pc),
      .fetch_epoch    (fetch_epoch),
      .redirect_valid (redirect_valid),
      .redirect_sel   (redirect_sel),
      .jal_target     (jal_target),
      .jalr_target    (jalr_target),
      .branch_target  (branch_target),
      .halted         (halted),
      .misalign       (misalign),
      .misalign_addr  (misalign_addr)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] pc;
      logic [1:0]  epoch;
      logic        valid;
      logic        hlt;
      logic        mis;
      logic [31:0] maddr;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   // Reference model state (0 idle, 1 run, 2 halt)
   int          m_state = 0;
   logic [31:0] m_pc    = 32'h0;
   logic [1:0]  m_epoch = 2'd0;
   logic        m_mis   = 1'b0;
   logic [31:0] m_maddr = 32'h0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one clock using the currently driven inputs.
   task automatic model_push();
      exp_t        e;
      logic [31:0] tgt;
      if (reset) begin
         m_state = 0; m_pc = RESET_VEC; m_epoch = 2'd0; m_mis = 1'b0; m_maddr = 32'h0;
      end else begin
         case (redirect_sel)
            2'd0: tgt = jal_target;
            2'd1: tgt = jalr_target & 32'hFFFF_FFFE;
            2'd2: tgt = branch_target;
            default: tgt = TRAP_VEC;
         endcase
         m_mis = 1'b0;
         if (redirect_valid && m_state != 0) begin
            m_epoch = m_epoch + 2'd1;
`ifdef PC_MISALIGN_EN
            if (redirect_sel != 2'd3 && tgt[1:0] != 2'b00) begin
               m_pc = TRAP_VEC; m_mis = 1'b1; m_maddr = tgt;
            end else begin
               m_pc = tgt;
            end
`else
            m_pc = tgt & 32'hFFFF_FFFC;
`endif
         end else if (m_state == 1 && fetch_ready) begin
            m_pc = m_pc + 32'd4;
         end
         if (m_state == 0 && start)     m_state = 1;
         else if (m_state == 1 && halt) m_state = 2;
         else if (m_state == 2 && !halt) m_state = 1;
      end
      e.pc = m_pc; e.epoch = m_epoch; e.valid = (m_state == 1); e.hlt = (m_state == 2);
      e.mis = m_mis; e.maddr = m_maddr;
      sb.push_back(e);
   endtask

   task automatic step(input logic rst, input logic st, input logic hl, input logic fr,
                       input logic rv, input logic [1:0] sel, input logic [31:0] tgt);
      exp_t e;
      reset = rst; start = st; halt = hl; fetch_ready = fr;
      redirect_valid = rv; redirect_sel = sel;
      // Non-selected targets carry decoys so a wrong mux leg is visible.
      jal_target    = (sel == 2'd0) ? tgt : tgt + 32'h20;
      jalr_target   = (sel == 2'd1) ? tgt : tgt + 32'h40;
      branch_target = (sel == 2'd2) ? tgt : tgt + 32'h80;
      model_push();
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check("fetch_pc",      fetch_pc,      e.pc);
         check("fetch_epoch",   fetch_epoch,   e.epoch);
         check("fetch_valid",   fetch_valid,   e.valid);
         check("halted",        halted,        e.hlt);
         check("misalign",      misalign,      e.mis);
         check("misalign_addr", misalign_addr, e.maddr);
      end
   endtask

   initial begin
      // Reset, then confirm the documented reset values directly.
      step(1, 0, 0, 0, 1, 2'd0, 32'h44);
      step(1, 0, 0, 0, 0, 2'd0, 32'h0);
      check("rst_pc", fetch_pc, RESET_VEC);
      check("rst_epoch", fetch_epoch, 2'd0);
      check("rst_valid", fetch_valid, 1'b0);

      // IDLE ignores redirects and halt.
      step(0, 0, 1, 1, 1, 2'd2, 32'h300);
      check("idle_ignores_redirect", fetch_pc, 32'h0);
      step(0, 1, 0, 1, 0, 2'd0, 32'h0);
      check("start_valid", fetch_valid, 1'b1);
      for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0, 2'd0, 32'h0);
      check("seq_pc_40", fetch_pc, 32'h40);
      check("seq_epoch_0", fetch_epoch, 2'd0);

      // Stall holds PC, then branch wins over the concurrent handshake.
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 2'd0, 32'h0);
      check("stall_pc", fetch_pc, 32'h40);
      step(0, 0, 0, 1, 1, 2'd2, 32'h200);
      check("branch_pc", fetch_pc, 32'h200);
      check("branch_epoch", fetch_epoch, 2'd1);

      // Four JALs wrap the 2-bit epoch back to where it started.
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 2'd0, 32'h300 + 32'(i * 8));
      check("epoch_wrap", fetch_epoch, 2'd1);
      step(0, 0, 0, 1, 1, 2'd1, 32'h1235);
      check("jalr_pc", fetch_pc, 32'h1234);

      // Halt, trap while halted, resume from TRAP_VEC.
      step(0, 0, 1, 1, 0, 2'd0, 32'h0);
      check("halt_halted", halted, 1'b1);
      step(0, 0, 1, 1, 0, 2'd0, 32'h0);
      step(0, 0, 1, 1, 1, 2'd3, 32'h0);
      check("trap_pc", fetch_pc, TRAP_VEC);
      step(0, 0, 0, 1, 0, 2'd0, 32'h0);
      step(0, 0, 0, 1, 0, 2'd0, 32'h0);
      check("resume_pc", fetch_pc, TRAP_VEC + 32'd4);

      // Misaligned branch target and the following cycle.
      step(0, 0, 0, 1, 1, 2'd2, 32'h102);
      check("misalign_pc", fetch_pc, 32'h100);
      step(0, 0, 0, 0, 0, 2'd0, 32'h0);
      check("misalign_drop", misalign, 1'b0);

      // Halt together with a redirect in RUN.
      step(0, 0, 1, 1, 1, 2'd0, 32'h500);
      check("halt_redirect_pc", fetch_pc, 32'h500);
      step(0, 0, 0, 0, 0, 2'd0, 32'h0);

      // PC wrap at the top of the address space.
      step(0, 0, 0, 1, 1, 2'd0, 32'hFFFF_FFFC);
      step(0, 0, 0, 1, 0, 2'd0, 32'h0);
      check("wrap_pc", fetch_pc, 32'h0);

      // Reset beats a concurrent redirect.
      step(1, 0, 0, 1, 1, 2'd2, 32'h700);
      check("rst_redirect_pc", fetch_pc, RESET_VEC);
      check("rst_redirect_epoch", fetch_epoch, 2'd0);

      // Randomised phase.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
